spi_cmd_decoder: RTL

//  Byte-level command decoder downstream of the SPI slave shifter inside spi_top. Parses frames
//  {cmd, data...} from received bytes and stages register writes in shadow copies. Commits them

---
 rtl/spi_dds_pkg.sv | 42 ++++
 rtl/spi_reg_bank.sv | 126 ++++++++++++
 rtl/spi_cmd_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_dds_pkg.sv
// Shared definitions for the SPI command path and the DDS core:
// register map, CTRL field positions, STATUS layout and decoder FSM states.
package spi_dds_pkg;

    localparam int ADDR_FREQ   = 0;
    localparam int ADDR_PHASE  = 1;
    localparam int ADDR_CTRL   = 2;
    localparam int ADDR_STATUS = 3;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_WAVE_LSB    = 1;
    localparam int CTRL_WAVE_W      = 2;
    localparam int CTRL_LED_LSB     = 3;
    localparam int CTRL_LED_W       = 4;
    localparam int CTRL_STORED_W    = 7;
    localparam int CTRL_CLR_ERR_BIT = 31;

    localparam int PHASE_W = 12;

    localparam int STATUS_FRAME_LSB = 16;
    localparam int STATUS_ERR_LSB   = 0;
    localparam int STATUS_CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_DRAIN
    } state_t;

    // Packs the frame and error counters into the STATUS register word.
    function automatic logic [31:0] packStatus(input logic [STATUS_CNT_W-1:0] frameCnt,
                                               input logic [STATUS_CNT_W-1:0] errCnt);
        logic [31:0] word;
        word = '0;
        word[STATUS_FRAME_LSB +: STATUS_CNT_W] = frameCnt;
        word[STATUS_ERR_LSB   +: STATUS_CNT_W] = errCnt;
        return word;
    endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// Shadow/active register pairs for FREQ, PHASE and CTRL plus the STATUS counters.
// Writes land in the shadow copies; a commit copies them to the active copies
// in one edge, a rollback restores the shadows from the active copies.
module spi_reg_bank
    import spi_dds_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] FREQ_RST = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wrEn,
    input  logic [ADDR_W-1:0]        i_wrAddr,
    input  logic [31:0]              i_wrData,
    input  logic                     i_commit,
    input  logic                     i_rollback,
    input  logic                     i_frameEnd,
    input  logic [ADDR_W-1:0]        i_rdAddr,
    output logic [31:0]              o_rdData,
    output logic [31:0]              o_freq,
    output logic [PHASE_W-1:0]       o_phase,
    output logic [CTRL_STORED_W-1:0] o_ctrl,
    output logic                     o_update,
    output logic                     o_frameErr
);

    logic [31:0]              r_shFreq,  r_actFreq;
    logic [PHASE_W-1:0]       r_shPhase, r_actPhase;
    logic [CTRL_STORED_W-1:0] r_shCtrl,  r_actCtrl;
    logic                     r_shClrErr;
    logic [STATUS_CNT_W-1:0]  r_frameCnt, r_errCnt;
    logic                     r_update, r_frameErr;

    logic [31:0]              w_nxFreq;
    logic [PHASE_W-1:0]       w_nxPhase;
    logic [CTRL_STORED_W-1:0] w_nxCtrl;
    logic                     w_nxClrErr;

    // Shadow contents including a write arriving this cycle, so a commit in
    // the same cycle as the last word's write still picks that word up.
    always_comb begin
        w_nxFreq   = r_shFreq;
        w_nxPhase  = r_shPhase;
        w_nxCtrl   = r_shCtrl;
        w_nxClrErr = r_shClrErr;
        if (i_wrEn) begin
            case (i_wrAddr)
                ADDR_W'(ADDR_FREQ):  w_nxFreq  = i_wrData;
                ADDR_W'(ADDR_PHASE): w_nxPhase = i_wrData[PHASE_W-1:0];
                ADDR_W'(ADDR_CTRL): begin
                    w_nxCtrl   = i_wrData[CTRL_STORED_W-1:0];
                    w_nxClrErr = i_wrData[CTRL_CLR_ERR_BIT];
                end
                default: ;
            endcase
        end
    end

    // Shadow/active registers, commit and rollback, sticky error and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shFreq   <= FREQ_RST;
            r_actFreq  <= FREQ_RST;
            r_shPhase  <= '0;
            r_actPhase <= '0;
            r_shCtrl   <= '0;
            r_actCtrl  <= '0;
            r_shClrErr <= 1'b0;
            r_frameCnt <= '0;
            r_errCnt   <= '0;
            r_update   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (i_commit) begin
                r_actFreq  <= w_nxFreq;
                r_actPhase <= w_nxPhase;
                r_actCtrl  <= w_nxCtrl;
                r_shFreq   <= w_nxFreq;
                r_shPhase  <= w_nxPhase;
                r_shCtrl   <= w_nxCtrl;
                r_shClrErr <= 1'b0;
                r_update   <= 1'b1;
                if (w_nxClrErr) begin
                    r_frameErr <= 1'b0;
                end
            end else if (i_rollback) begin
                r_shFreq   <= r_actFreq;
                r_shPhase  <= r_actPhase;
                r_shCtrl   <= r_actCtrl;
                r_shClrErr <= 1'b0;
                r_frameErr <= 1'b1;
                if (r_errCnt != {STATUS_CNT_W{1'b1}}) begin
                    r_errCnt <= r_errCnt + 1'b1;
                end
            end else begin
                r_shFreq   <= w_nxFreq;
                r_shPhase  <= w_nxPhase;
                r_shCtrl   <= w_nxCtrl;
                r_shClrErr <= w_nxClrErr;
            end
            if (i_frameEnd) begin
                r_frameCnt <= r_frameCnt + 1'b1;
            end
        end
    end

    // Read-back mux over the active registers; unmapped addresses read zero.
    always_comb begin
        o_rdData = '0;
        case (i_rdAddr)
            ADDR_W'(ADDR_FREQ):   o_rdData = r_actFreq;
            ADDR_W'(ADDR_PHASE):  o_rdData = {{(32-PHASE_W){1'b0}}, r_actPhase};
            ADDR_W'(ADDR_CTRL):   o_rdData = {{(32-CTRL_STORED_W){1'b0}}, r_actCtrl};
            ADDR_W'(ADDR_STATUS): o_rdData = packStatus(r_frameCnt, r_errCnt);
            default:              o_rdData = '0;
        endcase
    end

    assign o_freq     = r_actFreq;
    assign o_phase    = r_actPhase;
    assign o_ctrl     = r_actCtrl;
    assign o_update   = r_update;
    assign o_frameErr = r_frameErr;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Byte-level SPI command decoder: parses {cmd, data...} frames, stages writes
// into the register bank and serves read-back bytes to MISO.
// Optional build macro SPI_CMD_CHECKSUM_EN: write frames carry a trailing
// XOR checksum byte that must bring the XOR of all frame bytes to zero.
module spi_cmd_decoder
    import spi_dds_pkg::*;
#(
    parameter int          ADDR_W     = 7,
    parameter logic [7:0]  DEFAULT_TX = 8'hA5,
    parameter logic [31:0] FREQ_RST   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cs_active,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_tx_req,
    output logic [7:0]  o_tx_data,
    output logic [31:0] o_freq_word,
    output logic [11:0] o_phase_word,
    output logic        o_dds_en,
    output logic [1:0]  o_wave_sel,
    output logic [3:0]  o_led_groups,
    output logic        o_update,
    output logic        o_frame_err
);

`ifdef SPI_CMD_CHECKSUM_EN
    // With a checksum, a lone byte after the last full word is the checksum,
    // so an unmapped target is only certain once a second byte arrives.
    localparam logic [1:0] DRAIN_AT = 2'd1;
`else
    localparam logic [1:0] DRAIN_AT = 2'd0;
`endif

    state_t              r_state, w_nextState;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_byteCnt;
    logic [23:0]         r_wordBuf;
    logic                r_wordsDone;
    logic [7:0]          r_xor;
    logic                r_wrEn;
    logic [ADDR_W-1:0]   r_wrAddr;
    logic [31:0]         r_wrData;
    logic [31:0]         r_txBuf;
    logic [1:0]          r_txIdx;

    logic                w_frameEnd;
    logic                w_frameOk;
    logic                w_drainHit;
    logic                w_commit;
    logic                w_rollback;
    logic [ADDR_W-1:0]   w_rdAddr;
    logic [31:0]         w_rdData;
    logic [CTRL_STORED_W-1:0] w_ctrl;

    assign w_frameEnd = (r_state != ST_IDLE) && !i_cs_active && !i_rx_valid;
    assign w_drainHit = i_rx_valid && (r_byteCnt == DRAIN_AT) &&
                        (r_addr >= ADDR_W'(ADDR_STATUS));
`ifdef SPI_CMD_CHECKSUM_EN
    assign w_frameOk  = (r_byteCnt == 2'd1) && (r_xor == 8'h00);
`else
    assign w_frameOk  = (r_byteCnt == 2'd0);
`endif
    assign w_rdAddr   = (r_state == ST_CMD) ? i_rx_data[ADDR_W-1:0] : r_addr + ADDR_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the commit/rollback decision at frame end.
    always_comb begin
        w_nextState = r_state;
        w_commit    = 1'b0;
        w_rollback  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cs_active) w_nextState = ST_CMD;
            end
            ST_CMD: begin
                if (i_rx_valid) begin
                    w_nextState = i_rx_data[7] ? ST_RD : ST_WR;
                end else if (!i_cs_active) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_WR: begin
                if (w_frameEnd) begin
                    w_nextState = ST_IDLE;
                    if (r_wordsDone && w_frameOk) begin
                        w_commit = 1'b1;
                    end else if (r_wordsDone || (r_byteCnt != 2'd0)) begin
                        w_rollback = 1'b1;
                    end
                end else if (w_drainHit) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_RD: begin
                if (w_frameEnd) w_nextState = ST_IDLE;
            end
            ST_DRAIN: begin
                if (w_frameEnd) begin
                    w_nextState = ST_IDLE;
                    w_rollback  = 1'b1;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Byte assembly, checksum accumulation, staged writes and the tx buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_byteCnt   <= '0;
            r_wordBuf   <= '0;
            r_wordsDone <= 1'b0;
            r_xor       <= '0;
            r_wrEn      <= 1'b0;
            r_wrAddr    <= '0;
            r_wrData    <= '0;
            r_txBuf     <= '0;
            r_txIdx     <= '0;
        end else begin
            r_wrEn <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_byteCnt   <= '0;
                    r_wordsDone <= 1'b0;
                    r_xor       <= '0;
                end
                ST_CMD: begin
                    if (i_rx_valid) begin
                        r_addr <= i_rx_data[ADDR_W-1:0];
                        r_xor  <= i_rx_data;
                        if (i_rx_data[7]) begin
                            r_txBuf <= w_rdData;
                            r_txIdx <= 2'd3;
                        end
                    end
                end
                ST_WR: begin
                    if (i_rx_valid && !w_drainHit) begin
                        r_xor <= r_xor ^ i_rx_data;
                        if (r_byteCnt == 2'd3) begin
                            r_wrEn      <= 1'b1;
                            r_wrAddr    <= r_addr;
                            r_wrData    <= {r_wordBuf, i_rx_data};
                            r_addr      <= r_addr + ADDR_W'(1);
                            r_wordsDone <= 1'b1;
                            r_byteCnt   <= 2'd0;
                        end else begin
                            r_wordBuf <= {r_wordBuf[15:0], i_rx_data};
                            r_byteCnt <= r_byteCnt + 2'd1;
                        end
                    end
                end
                ST_RD: begin
                    if (i_tx_req) begin
                        if (r_txIdx == 2'd0) begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_txBuf <= w_rdData;
                            r_txIdx <= 2'd3;
                        end else begin
                            r_txIdx <= r_txIdx - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // MISO byte: current buffer byte while reading, idle pattern otherwise.
    always_comb begin
        o_tx_data = DEFAULT_TX;
        if (r_state == ST_RD) begin
            case (r_txIdx)
                2'd3:    o_tx_data = r_txBuf[31:24];
                2'd2:    o_tx_data = r_txBuf[23:16];
                2'd1:    o_tx_data = r_txBuf[15:8];
                default: o_tx_data = r_txBuf[7:0];
            endcase
        end
    end

    spi_reg_bank #(
        .ADDR_W   (ADDR_W),
        .FREQ_RST (FREQ_RST)
    ) u_regBank (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wrEn     (r_wrEn),
        .i_wrAddr   (r_wrAddr),
        .i_wrData   (r_wrData),
        .i_commit   (w_commit),
        .i_rollback (w_rollback),
        .i_frameEnd (w_frameEnd),
        .i_rdAddr   (w_rdAddr),
        .o_rdData   (w_rdData),
        .o_freq     (o_freq_word),
        .o_phase    (o_phase_word),
        .o_ctrl     (w_ctrl),
        .o_update   (o_update),
        .o_frameErr (o_frame_err)
    );

    assign o_dds_en     = w_ctrl[CTRL_EN_BIT];
    assign o_wave_sel   = w_ctrl[CTRL_WAVE_LSB +: CTRL_WAVE_W];
    assign o_led_groups = w_ctrl[CTRL_LED_LSB +: CTRL_LED_W];

endmodule
